// File: rtl/rv32_mem_stage_hs.sv
// ============================================================================
// rv32_mem_stage_hs : RV32 MEM stage with req/ack bus handshake and trap report
// Revision 1.0
// ============================================================================
`default_nettype none

module rv32_mem_stage_hs #(
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter logic [31:0] IO_MASK = 32'h8000_0000,
  parameter int          TIMEOUT = 255,
  parameter int          TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_data_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        wb_enable_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic        out_valid,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic [4:0]  wb_reg_out,
  output logic        wb_enable_out,
  output logic [31:0] wb_data_out,
  output logic        trap_out,
  output logic [1:0]  trap_cause,
  output logic        df_enable,
  output logic [4:0]  df_reg,
  output logic [31:0] df_data,
  output logic        load_busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d, bus_io_q, bus_io_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic        hold_wen_q, hold_wen_d;
  logic        out_valid_q, out_valid_d, wb_enable_out_q, wb_enable_out_d;
  logic [31:0] pc_out_q, pc_out_d, iw_out_q, iw_out_d, wb_data_out_q, wb_data_out_d;
  logic [4:0]  wb_reg_out_q, wb_reg_out_d;
  logic        trap_q, trap_d, df_enable_q, df_enable_d;
  logic [1:0]  cause_q, cause_d;

  logic [2:0]  f3, f3_q;
  logic        is_load, is_store, bad;
  logic [3:0]  be;
  logic [31:0] wdata, ext;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    f3       = iw_in[14:12];
    is_load  = (iw_in[6:0] == 7'b0000011);
    is_store = (iw_in[6:0] == 7'b0100011);
    bad      = ((f3[1:0] == 2'b01) && alu_in[0]) ||
               ((f3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00)) ||
               (is_load && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) ||
               (is_store && (f3 >= 3'b011));
    be    = 4'b0000;
    wdata = 32'h0;
    if (is_store) begin
      case (f3[1:0])
        2'b00:   begin be = 4'b0001 << alu_in[1:0]; wdata = {4{rs2_data_in[7:0]}}; end
        2'b01:   begin be = alu_in[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2_data_in[15:0]}}; end
        default: begin be = 4'b1111; wdata = rs2_data_in; end
      endcase
    end
  end

  // The held instruction and its address sit in the output registers while in REQ.
  always_comb begin
    f3_q  = iw_out_q[14:12];
    rbyte = bus_rdata[{wb_data_out_q[1:0], 3'b000} +: 8];
    rhalf = bus_rdata[{wb_data_out_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ext = {{24{rbyte[7]}}, rbyte};
      3'b001:  ext = {{16{rhalf[15]}}, rhalf};
      3'b100:  ext = {24'h0, rbyte};
      3'b101:  ext = {16'h0, rhalf};
      default: ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    bus_req_d       = bus_req_q;
    bus_we_d        = bus_we_q;
    bus_io_d        = bus_io_q;
    bus_addr_d      = bus_addr_q;
    bus_be_d        = bus_be_q;
    bus_wdata_d     = bus_wdata_q;
    cnt_d           = cnt_q;
    hold_wen_d      = hold_wen_q;
    out_valid_d     = 1'b0;
    pc_out_d        = pc_out_q;
    iw_out_d        = iw_out_q;
    wb_reg_out_d    = wb_reg_out_q;
    wb_enable_out_d = wb_enable_out_q;
    wb_data_out_d   = wb_data_out_q;
    trap_d          = trap_q;
    cause_d         = cause_q;
    in_ready        = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pc_out_d      = pc_in;
          iw_out_d      = iw_in;
          wb_reg_out_d  = wb_reg_in;
          wb_data_out_d = alu_in;
          trap_d        = 1'b0;
          cause_d       = 2'b00;
          if (!(is_load || is_store)) begin
            out_valid_d     = 1'b1;
            wb_enable_out_d = wb_enable_in;
          end else if (bad) begin
            out_valid_d     = 1'b1;
            wb_enable_out_d = 1'b0;
            trap_d          = 1'b1;
            cause_d         = 2'b01;
          end else begin
            state_d         = REQ;
            bus_req_d       = 1'b1;
            bus_we_d        = is_store;
            bus_io_d        = ((alu_in & IO_MASK) == IO_BASE);
            bus_addr_d      = alu_in[31:2];
            bus_be_d        = be;
            bus_wdata_d     = wdata;
            cnt_d           = TO_W'(1);
            hold_wen_d      = wb_enable_in & is_load;
            wb_enable_out_d = 1'b0;
          end
        end
      end
      REQ: begin
        // cnt_q numbers the current REQ cycle, starting at 1.
        cnt_d = cnt_q + TO_W'(1);
        if (bus_ack) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          out_valid_d = 1'b1;
          if (bus_err) begin
            trap_d          = 1'b1;
            cause_d         = 2'b10;
            wb_enable_out_d = 1'b0;
          end else begin
            wb_enable_out_d = hold_wen_q;
            if (!bus_we_q) wb_data_out_d = ext;
          end
        end else if (cnt_q == TO_W'(TIMEOUT)) begin
          state_d         = IDLE;
          bus_req_d       = 1'b0;
          out_valid_d     = 1'b1;
          trap_d          = 1'b1;
          cause_d         = 2'b11;
          wb_enable_out_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    df_enable_d = out_valid_d & wb_enable_out_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_io_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_be_q        <= '0;
      bus_wdata_q     <= '0;
      cnt_q           <= '0;
      hold_wen_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      pc_out_q        <= '0;
      iw_out_q        <= '0;
      wb_reg_out_q    <= '0;
      wb_enable_out_q <= 1'b0;
      wb_data_out_q   <= '0;
      trap_q          <= 1'b0;
      cause_q         <= '0;
      df_enable_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      bus_req_q       <= bus_req_d;
      bus_we_q        <= bus_we_d;
      bus_io_q        <= bus_io_d;
      bus_addr_q      <= bus_addr_d;
      bus_be_q        <= bus_be_d;
      bus_wdata_q     <= bus_wdata_d;
      cnt_q           <= cnt_d;
      hold_wen_q      <= hold_wen_d;
      out_valid_q     <= out_valid_d;
      pc_out_q        <= pc_out_d;
      iw_out_q        <= iw_out_d;
      wb_reg_out_q    <= wb_reg_out_d;
      wb_enable_out_q <= wb_enable_out_d;
      wb_data_out_q   <= wb_data_out_d;
      trap_q          <= trap_d;
      cause_q         <= cause_d;
      df_enable_q     <= df_enable_d;
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_io        = bus_io_q;
  assign bus_addr      = bus_addr_q;
  assign bus_be        = bus_be_q;
  assign bus_wdata     = bus_wdata_q;
  assign out_valid     = out_valid_q;
  assign pc_out        = pc_out_q;
  assign iw_out        = iw_out_q;
  assign wb_reg_out    = wb_reg_out_q;
  assign wb_enable_out = wb_enable_out_q;
  assign wb_data_out   = wb_data_out_q;
  assign trap_out      = trap_q;
  assign trap_cause    = cause_q;
  assign df_enable     = df_enable_q;
  assign df_reg        = wb_reg_out_q;
  assign df_data       = wb_data_out_q;
  assign load_busy     = (state_q == REQ) & ~bus_we_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32_mem_stage_hs.sv
// ============================================================================
// tb_rv32_mem_stage_hs : scoreboard bench for rv32_mem_stage_hs
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_rv32_mem_stage_hs;
  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
  logic [4:0]  wb_reg_in;
  logic        wb_enable_in;
  logic        bus_req, bus_we, bus_io;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;
  logic        out_valid;
  logic [31:0] pc_out, iw_out;
  logic [4:0]  wb_reg_out;
  logic        wb_enable_out;
  logic [31:0] wb_data_out;
  logic        trap_out;
  logic [1:0]  trap_cause;
  logic        df_enable;
  logic [4:0]  df_reg;
  logic [31:0] df_data;
  logic        load_busy;

  rv32_mem_stage_hs #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in), .rs2_data_in(rs2_data_in),
    .wb_reg_in(wb_reg_in), .wb_enable_in(wb_enable_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata), .out_valid(out_valid), .pc_out(pc_out), .iw_out(iw_out),
    .wb_reg_out(wb_reg_out), .wb_enable_out(wb_enable_out), .wb_data_out(wb_data_out),
    .trap_out(trap_out), .trap_cause(trap_cause), .df_enable(df_enable),
    .df_reg(df_reg), .df_data(df_data), .load_busy(load_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] iw;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic        chk_data;
    logic        trap;
    logic [1:0]  cause;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules written from the instruction-set view of each access.
  function automatic bit is_misaligned(input logic [31:0] iw, input logic [31:0] a);
    int f3 = int'(iw[14:12]);
    bit ld = (iw[6:0] == 7'h03);
    if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 1;
    if (!ld && f3 >= 3) return 1;
    if ((f3 % 4) == 1) return (a % 2) != 0;
    if ((f3 % 4) == 2) return (a % 4) != 0;
    return 0;
  endfunction

  function automatic logic [31:0] load_value(input int f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4: return b;
      5: return h;
      default: return rd;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("pc_out", pc_out, e.pc);
        check("iw_out", iw_out, e.iw);
        check("wb_reg_out", 32'(wb_reg_out), 32'(e.rd));
        check("wb_enable_out", 32'(wb_enable_out), 32'(e.wen));
        check("trap_out", 32'(trap_out), 32'(e.trap));
        check("trap_cause", 32'(trap_cause), 32'(e.cause));
        check("df_enable", 32'(df_enable), 32'(e.wen));
        check("df_reg", 32'(df_reg), 32'(e.rd));
        if (e.chk_data) begin
          check("wb_data_out", wb_data_out, e.data);
          check("df_data", df_data, e.data);
        end
      end
    end
  end

  task automatic check_bus(input bit st, input logic [31:0] a, input logic [31:0] rs2, input int f3);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    ebe = 4'h0;
    ewd = 32'h0;
    if (st) begin
      if (f3 == 0) begin ebe = 4'(1 << (a % 4)); ewd = (rs2 & 32'hFF) * 32'h0101_0101; end
      else if (f3 == 1) begin ebe = 4'(3 << (2 * ((a / 2) % 2))); ewd = (rs2 & 32'hFFFF) * 32'h0001_0001; end
      else begin ebe = 4'hF; ewd = rs2; end
    end
    check("bus_req", 32'(bus_req), 32'd1);
    check("bus_we", 32'(bus_we), 32'(st));
    check("bus_io", 32'(bus_io), 32'(a >= 32'h8000_0000));
    check("bus_addr", 32'(bus_addr), a / 4);
    check("bus_be", 32'(bus_be), 32'(ebe));
    if (st) check("bus_wdata", bus_wdata, ewd);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    check("load_busy", 32'(load_busy), 32'(!st));
  endtask

  task automatic run_op(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] a,
                        input logic [31:0] rs2, input bit wen, input int delay,
                        input bit err, input logic [31:0] rdata, input bit tmo);
    exp_t e;
    bit   ld, st, mis;
    int   f3, n;
    ld  = (iw[6:0] == 7'h03);
    st  = (iw[6:0] == 7'h23);
    f3  = int'(iw[14:12]);
    mis = (ld || st) && is_misaligned(iw, a);
    e.pc = pc; e.iw = iw; e.rd = iw[11:7];
    e.wen = wen; e.data = a; e.chk_data = 1; e.trap = 0; e.cause = 2'b00;
    if (mis) begin e.wen = 0; e.trap = 1; e.cause = 2'b01; e.chk_data = 0; end
    else if ((ld || st) && tmo) begin e.wen = 0; e.trap = 1; e.cause = 2'b11; e.chk_data = 0; end
    else if ((ld || st) && err) begin e.wen = 0; e.trap = 1; e.cause = 2'b10; e.chk_data = 0; end
    else if (ld) e.data = load_value(f3, a, rdata);
    else if (st) e.wen = 0;

    check("in_ready_idle", 32'(in_ready), 32'd1);
    pc_in = pc; iw_in = iw; alu_in = a; rs2_data_in = rs2;
    wb_reg_in = iw[11:7]; wb_enable_in = wen; in_valid = 1'b1;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    pc_in = $urandom; iw_in = $urandom; alu_in = $urandom; rs2_data_in = $urandom;
    if (!(ld || st) || mis) begin
      check("no_bus_req", 32'(bus_req), 32'd0);
    end else begin
      check_bus(st, a, rs2, f3);
      check("out_valid_busy", 32'(out_valid), 32'd0);
      if (tmo) begin
        n = 0;
        while (bus_req && n < TIMEOUT + 20) begin @(posedge clk); #1; n++; end
        check("timeout_window_ok", 32'(n == TIMEOUT || n == TIMEOUT + 1), 32'd1);
      end else begin
        repeat (delay) @(posedge clk);
        #1 check_bus(st, a, rs2, f3);
        bus_ack = 1'b1; bus_err = err; bus_rdata = rdata;
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      end
      check("bus_req_dropped", 32'(bus_req), 32'd0);
      check("in_ready_after", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] iw, a;
    int kind, f3;
    reset = 1'b0; in_valid = 1'b0; pc_in = 0; iw_in = 0; alu_in = 0; rs2_data_in = 0;
    wb_reg_in = 0; wb_enable_in = 0; bus_ack = 0; bus_err = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_trap_out", 32'(trap_out), 32'd0);
    check("rst_df_enable", 32'(df_enable), 32'd0);
    check("rst_wb_data_out", wb_data_out, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(32'h100, 32'h0050_0093, 32'd5, 0, 1, 0, 0, 0, 0);                    // ADDI
    run_op(32'h104, 32'h0000_0023, 32'h0000_1002, 32'hAB, 0, 3, 0, 0, 0);       // SB
    run_op(32'h108, 32'h0000_0183, 32'd3, 0, 1, 1, 0, 32'h8011_2233, 0);        // LB
    run_op(32'h10C, 32'h0000_4183, 32'd3, 0, 1, 0, 0, 32'h8011_2233, 0);        // LBU
    run_op(32'h110, 32'h0000_5183, 32'd2, 0, 1, 2, 0, 32'h8011_2233, 0);        // LHU
    run_op(32'h114, 32'h0000_2203, 32'h8000_0010, 0, 1, 1, 1, 32'h1234_5678, 0); // LW err
    run_op(32'h118, 32'h0000_1283, 32'd1, 0, 1, 0, 0, 0, 0);                    // LH misaligned
    run_op(32'h11C, 32'h0000_2023, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);      // SW timeout

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      kind = $urandom_range(0, 9);
      f3   = $urandom_range(0, 7);
      iw   = $urandom;
      iw[14:12] = 3'(f3);
      if (kind < 3)      iw[6:0] = (kind == 0) ? 7'h13 : (kind == 1) ? 7'h33 : 7'h37;
      else if (kind < 7) iw[6:0] = 7'h03;
      else               iw[6:0] = 7'h23;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) != 0) a[31] = 1'b0;
      run_op($urandom, iw, a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
             ($urandom_range(0, 7) == 0), $urandom, 0);
    end

    // Abandon an in-flight load with reset, then offer a stale ack.
    pc_in = 32'h200; iw_in = 32'h0000_2303; alu_in = 32'h40; wb_reg_in = 5'd6;
    wb_enable_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_req_bus_req", 32'(bus_req), 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1 check("async_rst_bus_req", 32'(bus_req), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1 bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1 bus_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("late_ack_out_valid", 32'(out_valid), 32'd0);
      check("late_ack_bus_req", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rv32_mem_stage_hs.md
Name: rv32_mem_stage_hs

Overview:
Parametrised successor to the single-cycle MEM stage. It sits between EX/MEM and MEM/WB and talks to a multi-cycle memory/IO bus through a req/ack handshake, stalling the upstream pipeline while a bus access is outstanding. Within the stage it performs:
- store byte-lane steering;
- load alignment, sign extension and zero extension;
- address-window decode of the IO region;
- misalignment and bus-error/timeout trap reporting.

Parameters:
IO_BASE, 32'h8000_0000, base address of IO window
IO_MASK, 32'h8000_0000, address bits compared against IO_BASE; (addr & IO_MASK)==IO_BASE selects IO
TIMEOUT, 255, max cycles waiting for bus_ack before trap (1..65535)
TO_W, 8, width of timeout counter (>= clog2(TIMEOUT+1))

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  EX/MEM holds a valid instruction
in_ready  out  1  stage accepts in_* this cycle; 0 = upstream stall
pc_in  in  32  instruction PC
iw_in  in  32  instruction word (opcode iw[6:0], funct3 iw[14:12])
alu_in  in  32  ALU result / effective address
rs2_data_in  in  32  store data
wb_reg_in  in  5  destination register
wb_enable_in  in  1  instruction writes a register
bus_req  out  1  bus request, held until bus_ack
bus_we  out  1  1 = store
bus_io  out  1  1 = IO window, 0 = memory
bus_addr  out  30  word address [31:2]
bus_be  out  4  byte enables (0000 on loads)
bus_wdata  out  32  lane-steered store data
bus_ack  in  1  access complete; bus_rdata valid same cycle
bus_err  in  1  qualified by bus_ack; access faulted
bus_rdata  in  32  raw load word
out_valid  out  1  MEM/WB register valid
pc_out  out  32  registered PC
iw_out  out  32  registered instruction
wb_reg_out  out  5  registered destination
wb_enable_out  out  1  register write enable (0 on trap)
wb_data_out  out  32  extended load data or alu_in
trap_out  out  1  instruction faulted
trap_cause  out  2  01 misaligned, 10 bus_err, 11 timeout, 00 none
df_enable  out  1  forwarding valid (registered result, wb_enable_out & out_valid)
df_reg  out  5  forwarding register
df_data  out  32  forwarding data (= wb_data_out)
load_busy  out  1  load in flight; EX must not forward from this stage

Behaviour:
- Reset (reset low, async): state IDLE; every output register is 0. Consequently bus_req, out_valid, trap_out and df_enable are 0; in_ready=1 once reset is released.
- Mem op: opcode 0000011 (load) or 0100011 (store). Every other valid instruction is a non-mem op.
- Misalignment check:
  - halfword with alu_in[0]=1 is misaligned;
  - word with alu_in[1:0]!=0 is misaligned;
  - byte accesses are never misaligned.
- Illegal load funct3 (011/110/111) and illegal store funct3 (>=011) are reported as trap_cause 01.
- FSM states IDLE, REQ.
- IDLE, in_valid=0: next cycle out_valid=0.
- IDLE, non-mem op: registered next cycle. out_valid=1, wb_data_out=alu_in, trap 0. Latency 1.
- IDLE, misaligned mem op: no bus access. Next cycle out_valid=1, trap_out=1, trap_cause=01, wb_enable_out=0.
- IDLE, aligned mem op: latch the request into bus_* registers and go to REQ.
  - bus_req=1 from the next cycle.
  - in_ready=0 and out_valid=0 while in REQ.
- REQ: bus_addr, bus_we, bus_be, bus_wdata and bus_io are stable until ack.
  - Timeout counter increments each REQ cycle.
- REQ and bus_ack=1 (takes priority over timeout on the same cycle): return to IDLE and drop bus_req. Next cycle out_valid=1.
  - Load: wb_data_out = extended load data.
  - bus_err=1: trap_out=1, trap_cause=10, wb_enable_out=0.
- REQ and counter==TIMEOUT with no ack: drop bus_req and return to IDLE. out_valid=1, trap_cause=11, wb_enable_out=0. Best-case mem latency is 2 cycles.
- Store lanes:
  - SB: be=0001<<a[1:0], wdata=rs2[7:0] replicated to all lanes.
  - SH: be = a[1] ? 1100 : 0011, wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Load extract: byte = rdata[8*a[1:0]+:8], half = rdata[16*a[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Stores: wb_data_out=alu_in, and wb_enable_out is forced 0.
- load_busy = (state==REQ) & ~bus_we.
- Reset asserted mid-REQ: bus_req drops immediately (async). The in-flight access is abandoned and its late ack is ignored.
- bus_ack while IDLE is ignored.

Test Plan:
- ADDI (iw 0x00500093, alu 5, rd 1) -> 1 cycle later out_valid=1, wb_data_out=5, df_reg=1, no bus_req.
- SB rs2=0x000000AB, alu=0x0000_1002 -> bus_req, bus_io=0, be=0100, wdata=0xABABABAB, addr=0x400; ack after 3 cycles -> in_ready=1 next cycle, wb_enable_out=0.
- LB alu=0x0000_0003, rdata=0x80112233 -> wb_data_out=0xFFFFFF80; LBU same -> 0x00000080; LHU alu=2 -> 0x00008011.
- LW alu=0x8000_0010 -> bus_io=1; bus_ack with bus_err=1 -> trap_out=1, trap_cause=10, wb_enable_out=0.
- LH alu=0x0000_0001 -> no bus_req, trap_cause=01; SW with ack never returned -> after TIMEOUT(255) cycles trap_cause=11, bus_req=0.
- reset pulled low mid-REQ -> bus_req=0 asynchronously; after release, a late bus_ack produces no out_valid.
